pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Fetch-stage next-PC controller. Drives the data and 2-bit mode inputs of the 32-bit PC accumulate register: 00 load, 01 signed add, 10 subtract, 11 hold.
- Each cycle it chooses between boot load, sequential increment, stall hold, and jump/branch redirect.
- Holds a redirect that arrives during a stall and generates the IF/ID flush window.

Parameters:
- RESET_VECTOR, 32'h0000_0000, address loaded into PC on the first cycle after reset.
- PC_INC, 32'd4, increment added each normal fetch cycle.
- FLUSH_CYCLES, 2, cycles FlushOut stays high after a redirect issues (1..7).

Ports:
- Clk  input  1  clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high.
- Stall  input  1  hazard unit: freeze PC this cycle.
- JumpEn  input  1  jump resolved this cycle.
- JumpAddr  input  32  absolute jump target.
- BranchTaken  input  1  conditional branch resolved taken this cycle.
- BranchTarget  input  32  absolute branch target.
- PCIn  output  32  data to PC register.
- PCSignal  output  2  mode to PC register.
- FlushOut  output  1  squash IF/ID contents.
- RedirPending  output  1  a redirect is held waiting for Stall to drop.

Behaviour:
- All outputs are registered. Values computed at posedge N are consumed by the PC register at posedge N+1.
- Reset (sampled high at posedge) sets:
  - state = BOOT
  - PCIn = 0, PCSignal = 2'b11
  - FlushOut = 1, RedirPending = 0
  - flush counter = 0, pending register cleared
- Reset mid-operation discards any pending redirect and any flush window.
- States:
  - BOOT: one cycle. Output PCIn = RESET_VECTOR, PCSignal = 00, FlushOut = 1. Go to RUN. Stall, JumpEn and BranchTaken are ignored in BOOT.
  - RUN: evaluate the request in the priority order below.
  - HOLD: entered when a redirect is captured while Stall is high. Output PCSignal = 11, PCIn = 0. When Stall drops, issue the pending redirect and go to RUN.
- Priority within RUN: Jump > Branch > Stall > increment.
  - JumpEn=1 and Stall=0: PCIn = JumpAddr, PCSignal = 00, start flush.
  - BranchTaken=1 and Stall=0: PCIn = BranchTarget, PCSignal = 00, start flush.
  - JumpEn and BranchTaken both 1: jump wins; the branch is dropped.
  - Redirect with Stall=1: capture the target into the pending register, set RedirPending=1, output hold (11), go to HOLD.
  - Stall=1 with no redirect: PCIn = 0, PCSignal = 11.
  - Otherwise: PCIn = PC_INC, PCSignal = 01.
- Pending rules:
  - Only the first redirect is kept. New JumpEn/BranchTaken while RedirPending=1 are ignored, because the older instruction in program order wins.
  - RedirPending clears on the same posedge that issues the pending load.
- Start flush: flush counter = FLUSH_CYCLES, FlushOut = 1.
  - The counter decrements each cycle while nonzero. FlushOut = (counter != 0).
  - A redirect issued during an active flush reloads the counter to FLUSH_CYCLES.
  - Stall does not pause the counter.
- PCIn and PCSignal are never X after reset. PCSignal never takes the value 10 unless the optional feature is enabled.

Optional Feature:
- Macro: PC_SEQ_REL_BRANCH_EN.
- Enabled:
  - Adds input BranchRel (1) and input BranchOffset (32, signed byte offset relative to the current PC register value).
  - Taken branch with BranchRel=1:
    - BranchOffset >= 0: PCSignal = 01, PCIn = BranchOffset.
    - BranchOffset < 0: PCSignal = 10, PCIn = -BranchOffset.
  - Pending capture stores the offset and the relative flag.
- Disabled: the ports are absent; all branches are absolute loads (00).

Test Plan:
- Reset 3 cycles, then free run with RESET_VECTOR=32'h100 -> cycle 1: PCIn=0x100, sig 00, FlushOut=1. Following cycles: PCIn=4, sig 01. Modelled PC: 0x100, 0x104, 0x108.
- Stall high for 2 cycles in RUN -> two cycles of sig 11, PCIn=0. Increment resumes after; modelled PC frozen for exactly 2 cycles.
- JumpEn=1, JumpAddr=0x2000 with BranchTaken=1, BranchTarget=0x3000 in the same cycle -> PCIn=0x2000, sig 00. FlushOut high 2 cycles, then low.
- BranchTaken=1 (target 0x40) during Stall, JumpEn (0x80) one cycle later while still stalled, Stall drops -> RedirPending=1 for the stall duration. The load issued is 0x40; 0x80 is never issued.
- Redirect, then a second redirect 1 cycle later -> FlushOut stays high continuously for 3 cycles total. Reset asserted mid-HOLD -> RedirPending=0 and BOOT reload of RESET_VECTOR.
- With PC_SEQ_REL_BRANCH_EN, PC=0x200: taken relative branch with offset -16 -> sig 10, PCIn=16, modelled PC=0x1F0. Offset +8 -> sig 01, PCIn=8.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bundle between the hazard/branch units (master) and the next-PC sequencer (slave).
// The BranchRel/BranchOffset members exist only when PC_SEQ_REL_BRANCH_EN is defined.
interface pc_sequencer_if;
    logic        Stall;
    logic        JumpEn;
    logic [31:0] JumpAddr;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
`ifdef PC_SEQ_REL_BRANCH_EN
    logic        BranchRel;
    logic [31:0] BranchOffset;
`endif
    logic [31:0] PCIn;
    logic [1:0]  PCSignal;
    logic        FlushOut;
    logic        RedirPending;

    modport master (
`ifdef PC_SEQ_REL_BRANCH_EN
        output BranchRel, BranchOffset,
`endif
        output Stall, JumpEn, JumpAddr, BranchTaken, BranchTarget,
        input  PCIn, PCSignal, FlushOut, RedirPending
    );

    modport slave (
`ifdef PC_SEQ_REL_BRANCH_EN
        input  BranchRel, BranchOffset,
`endif
        input  Stall, JumpEn, JumpAddr, BranchTaken, BranchTarget,
        output PCIn, PCSignal, FlushOut, RedirPending
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller: drives data/mode of the PC accumulate register and the IF/ID flush.
// Define PC_SEQ_REL_BRANCH_EN to add PC-relative branches (add/subtract modes).
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_INC       = 32'd4,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] { BOOT, RUN, HOLD } state_t;

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_ADD   = 2'b01;
`ifdef PC_SEQ_REL_BRANCH_EN
    localparam logic [1:0] MODE_SUB   = 2'b10;
`endif
    localparam logic [1:0] MODE_HOLD  = 2'b11;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state, state_next;
    logic [31:0] pc_in_q, pc_in_d;
    logic [1:0]  pc_sig_q, pc_sig_d;
    logic        flush_q, flush_d;
    logic [2:0]  flush_cnt, flush_cnt_d;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        redir_req, issue, capture, release_pend;
    logic [31:0] req_target, sel_target, redir_pc;
    logic [1:0]  redir_sig;
`ifdef PC_SEQ_REL_BRANCH_EN
    logic        req_rel, pend_rel, sel_rel;
`endif

    assign redir_req = bus.JumpEn | bus.BranchTaken;

    // A jump always beats a branch; a relative branch carries its offset in the target slot.
    always_comb begin
        req_target = bus.JumpEn ? bus.JumpAddr : bus.BranchTarget;
`ifdef PC_SEQ_REL_BRANCH_EN
        req_rel = ~bus.JumpEn & bus.BranchTaken & bus.BranchRel;
        if (req_rel)
            req_target = bus.BranchOffset;
`endif
    end

    always_comb begin
        sel_target = (state == HOLD) ? pend_target : req_target;
        redir_pc   = sel_target;
        redir_sig  = MODE_LOAD;
`ifdef PC_SEQ_REL_BRANCH_EN
        sel_rel = (state == HOLD) ? pend_rel : req_rel;
        if (sel_rel) begin
            if (sel_target[31]) begin
                redir_pc  = -sel_target;
                redir_sig = MODE_SUB;
            end else begin
                redir_sig = MODE_ADD;
            end
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= BOOT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redir_req && bus.Stall) state_next = HOLD;
            HOLD:    if (!bus.Stall) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // While HOLD, new redirects are ignored: the older instruction already owns the pending slot.
    always_comb begin
        pc_in_d      = '0;
        pc_sig_d     = MODE_HOLD;
        issue        = 1'b0;
        capture      = 1'b0;
        release_pend = 1'b0;
        case (state)
            BOOT: begin
                pc_in_d  = RESET_VECTOR;
                pc_sig_d = MODE_LOAD;
            end
            RUN: begin
                if (redir_req && bus.Stall) begin
                    capture = 1'b1;
                end else if (redir_req) begin
                    issue = 1'b1;
                end else if (!bus.Stall) begin
                    pc_in_d  = PC_INC;
                    pc_sig_d = MODE_ADD;
                end
            end
            HOLD: begin
                if (!bus.Stall) begin
                    issue        = 1'b1;
                    release_pend = 1'b1;
                end
            end
            default: ;
        endcase
        if (issue) begin
            pc_in_d  = redir_pc;
            pc_sig_d = redir_sig;
        end
        flush_cnt_d = '0;
        if (issue)
            flush_cnt_d = FLUSH_LOAD;
        else if (flush_cnt != '0)
            flush_cnt_d = flush_cnt - 3'd1;
        flush_d = (state == BOOT) || (flush_cnt_d != '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_in_q     <= '0;
            pc_sig_q    <= MODE_HOLD;
            flush_q     <= 1'b1;
            flush_cnt   <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
`ifdef PC_SEQ_REL_BRANCH_EN
            pend_rel    <= 1'b0;
`endif
        end else begin
            pc_in_q   <= pc_in_d;
            pc_sig_q  <= pc_sig_d;
            flush_q   <= flush_d;
            flush_cnt <= flush_cnt_d;
            if (capture) begin
                pend_valid  <= 1'b1;
                pend_target <= req_target;
`ifdef PC_SEQ_REL_BRANCH_EN
                pend_rel    <= req_rel;
`endif
            end else if (release_pend) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.PCIn         = pc_in_q;
    assign bus.PCSignal     = pc_sig_q;
    assign bus.FlushOut     = flush_q;
    assign bus.RedirPending = pend_valid;

endmodule
